// File: rtl/counter_ramp_ctrl_pkg.sv
// Shared definitions for the ramp controller and the up/down counter it drives.
package counter_ramp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_STEP,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/counter_ramp_ctrl_prescaler.sv
// Loadable down-counter with zero flag; paces rate-controlled sequencers.
module ramp_prescaler #(
  parameter int RATE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [RATE_W-1:0] i_value,
  output logic              o_zero
);

  logic [RATE_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/counter_ramp_ctrl.sv
// Steps an up/down counter from its present value to a commanded target at a
// programmable rate, reporting done, stall or abort to the command issuer.
module counter_ramp_ctrl
  import counter_ramp_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RATE_W    = 4,
  parameter int STALL_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_target,
  input  logic [RATE_W-1:0] cmd_rate,
  input  logic              abort,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic              cnt_en,
  output logic              cnt_up,
  output logic              busy,
  output logic              done,
  output logic              stall_err,
  output logic              aborted
);

  localparam int SC_W = $clog2(STALL_MAX + 1);

  state_e            r_state, w_next;
  logic [WIDTH-1:0]  r_target, r_last;
  logic [RATE_W-1:0] r_rate;
  logic              r_dir, w_dir_next;
  logic [SC_W-1:0]   r_stall_cnt, w_stall_next, w_stall_eval;
  logic              r_done, r_stall_err, r_aborted;
  logic              w_done_set, w_stall_set, w_abort_set;
  logic              w_accept, w_pre_load, w_pre_zero;
  logic              w_cmp_eq, w_cmp_dir;

  ramp_prescaler #(.RATE_W(RATE_W)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_pre_load),
    .i_value (r_rate),
    .o_zero  (w_pre_zero)
  );

  assign w_cmp_eq     = (cnt_in == r_target);
  assign w_cmp_dir    = (cnt_in < r_target) ? DIR_UP : DIR_DN;
  assign w_stall_eval = (cnt_in == r_last) ? r_stall_cnt + 1'b1 : '0;

  // The last WAIT cycle makes the CHECK decision itself, so that a step
  // interval is rate+2 cycles while the counter still gets a settle cycle.
  always_comb begin
    w_next       = r_state;
    w_dir_next   = r_dir;
    w_stall_next = r_stall_cnt;
    w_stall_set  = 1'b0;
    w_abort_set  = 1'b0;
    w_accept     = 1'b0;
    w_pre_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept     = 1'b1;
          w_stall_next = '0;
          w_next       = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_cmp_eq) begin
          w_next = ST_DONE;
        end else begin
          w_dir_next = w_cmp_dir;
          w_next     = ST_STEP;
        end
      end
      ST_STEP: begin
        w_pre_load = 1'b1;
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_pre_zero) begin
          w_stall_next = w_stall_eval;
          if (w_stall_eval == SC_W'(STALL_MAX)) begin
            w_stall_set = 1'b1;
            w_next      = ST_IDLE;
          end else if (w_cmp_eq) begin
            w_next = ST_DONE;
          end else begin
            w_dir_next = w_cmp_dir;
            w_next     = ST_STEP;
          end
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE)) begin
      w_next      = ST_IDLE;
      w_abort_set = 1'b1;
      w_stall_set = 1'b0;
    end
  end

  assign w_done_set = (w_next == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_target    <= '0;
      r_rate      <= '0;
      r_dir       <= 1'b0;
      r_last      <= '0;
      r_stall_cnt <= '0;
      r_done      <= 1'b0;
      r_stall_err <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_dir       <= w_dir_next;
      r_stall_cnt <= w_stall_next;
      r_done      <= w_done_set;
      r_stall_err <= w_stall_set;
      r_aborted   <= w_abort_set;
      if (w_accept) begin
        r_target <= cmd_target;
        r_rate   <= cmd_rate;
      end
      if (r_state == ST_STEP) begin
        r_last <= cnt_in;
      end
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign cnt_en    = (r_state == ST_STEP) & ~abort;
  assign cnt_up    = r_dir;
  assign done      = r_done;
  assign stall_err = r_stall_err;
  assign aborted   = r_aborted;

endmodule

// File: tb/tb_counter_ramp_ctrl.sv
// Scoreboard bench for counter_ramp_ctrl driving a behavioural saturating counter.
module tb_counter_ramp_ctrl;
  import counter_ramp_ctrl_pkg::*;

  localparam int WIDTH     = 8;
  localparam int RATE_W    = 4;
  localparam int STALL_MAX = 3;
  localparam int K_DONE    = 0;
  localparam int K_STALL   = 1;
  localparam int K_ABORT   = 2;

  typedef struct {
    int kind;
    int n;
    int dir;
    int rate;
    int lat;
    int fin;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              abort = 1'b0;
  logic [WIDTH-1:0]  cmd_target = '0;
  logic [RATE_W-1:0] cmd_rate = '0;
  logic [WIDTH-1:0]  cnt = '0;
  logic              cmd_ready, cnt_en, cnt_up, busy, done, stall_err, aborted;
  logic              ld = 1'b0;
  logic              en_ok = 1'b1;
  logic [WIDTH-1:0]  ld_val = '0;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int mstart = 0;
  int rel = 0;
  bit active = 1'b0;

  always #5 clk = ~clk;

  counter_ramp_ctrl #(.WIDTH(WIDTH), .RATE_W(RATE_W), .STALL_MAX(STALL_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_rate   (cmd_rate),
    .abort      (abort),
    .cnt_in     (cnt),
    .cnt_en     (cnt_en),
    .cnt_up     (cnt_up),
    .busy       (busy),
    .done       (done),
    .stall_err  (stall_err),
    .aborted    (aborted)
  );

  // Saturating up/down counter under control; en_ok=0 models an en pin tied low.
  always @(posedge clk) begin
    if (ld) cnt <= ld_val;
    else if (cnt_en && en_ok) begin
      if (cnt_up && cnt != 8'hFF) cnt <= cnt + 1'b1;
      else if (!cnt_up && cnt != 8'h00) cnt <= cnt - 1'b1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
  endtask

  // Monitor: derives the expected cycle-by-cycle response of the active command.
  always @(negedge clk) begin
    bit e_busy, e_en, e_done, e_stall, e_abort;
    cyc++;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_cnt_en", cnt_en, 0);
      chk("rst_cnt_up", cnt_up, 0);
      chk("rst_pulses", {29'd0, done, stall_err, aborted}, 0);
      active = 1'b0;
    end else begin
      e_busy = 0; e_en = 0; e_done = 0; e_stall = 0; e_abort = 0;
      if (active) begin
        rel     = cyc - mstart;
        e_busy  = (rel >= 1) && ((rel < cur.lat) || (rel == cur.lat && cur.kind == K_DONE));
        e_en    = (rel >= 2) && (((rel - 2) % (cur.rate + 2)) == 0)
                  && (((rel - 2) / (cur.rate + 2)) < cur.n);
        e_done  = (rel == cur.lat) && (cur.kind == K_DONE);
        e_stall = (rel == cur.lat) && (cur.kind == K_STALL);
        e_abort = (rel == cur.lat) && (cur.kind == K_ABORT);
      end
      chk("busy", busy, e_busy);
      chk("cmd_ready", cmd_ready, !e_busy);
      chk("cnt_en", cnt_en, e_en);
      chk("done", done, e_done);
      chk("stall_err", stall_err, e_stall);
      chk("aborted", aborted, e_abort);
      if (e_en && cnt_en) chk("cnt_up", cnt_up, cur.dir);
      if (active && rel == cur.lat) begin
        chk("final_count", cnt, cur.fin);
        active = 1'b0;
      end
      if (!active && cmd_valid && cmd_ready) begin
        if (q.size() == 0) chk("unexpected_accept", 1, 0);
        else begin
          cur    = q.pop_front();
          mstart = cyc;
          active = 1'b1;
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((active || q.size() != 0) && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 5000) chk("idle_timeout", 0, 1);
  endtask

  // Reference model: outcome of a command from start value, target and counter health.
  task automatic issue(input int s, input int t, input int r, input bit enok, input int abort_after);
    exp_t e;
    int a;
    wait_idle();
    en_ok = enok;
    @(posedge clk); #1;
    ld = 1'b1; ld_val = WIDTH'(s);
    @(posedge clk); #1;
    ld = 1'b0;
    e.rate = r;
    e.dir  = (t > s) ? 1 : 0;
    if (s == t) begin
      e.kind = K_DONE; e.n = 0; e.fin = s;
    end else if (!enok) begin
      e.kind = K_STALL; e.n = STALL_MAX; e.fin = s;
    end else begin
      e.kind = K_DONE; e.n = (t > s) ? t - s : s - t; e.fin = t;
    end
    if (abort_after >= 0 && abort_after < e.n) begin
      e.kind = K_ABORT;
      e.n    = abort_after;
      e.fin  = (t > s) ? s + abort_after : s - abort_after;
    end
    e.lat = 2 + e.n * (r + 2) + ((e.kind == K_ABORT) ? 1 : 0);
    q.push_back(e);
    cmd_valid = 1'b1; cmd_target = WIDTH'(t); cmd_rate = RATE_W'(r);
    @(posedge clk); #1;
    cmd_target = WIDTH'($urandom); cmd_rate = RATE_W'($urandom);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (e.kind == K_ABORT) begin
      a = 2 + e.n * (r + 2);
      repeat (a - 2) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, t, d, r, mode, k;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(8'h00, 8'h05, 0, 1'b1, -1);
    issue(8'h10, 8'h0C, 3, 1'b1, -1);
    issue(8'h22, 8'h22, 5, 1'b1, -1);
    issue(8'h00, 8'h80, 2, 1'b1, 3);
    issue(8'h00, 8'h03, 1, 1'b0, -1);

    // Reset in the STEP cycle right after the counter reaches 0x07.
    issue(8'h00, 8'h0F, 0, 1'b1, -1);
    k = 0;
    while (cnt != 8'h07 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_0x07", cnt, 8'h07);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_now_cnt_en", cnt_en, 0);
    chk("rst_now_busy", busy, 0);
    chk("rst_now_ready", cmd_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_counter_frozen", cnt, 8'h07);
    rst = 1'b0;
    issue(8'h07, 8'h0A, 1, 1'b1, -1);

    for (int i = 0; i < 40; i++) begin
      wait_idle();
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
      end
      s    = $urandom_range(0, 255);
      d    = $urandom_range(0, 24) - 12;
      t    = s + d;
      if (t < 0) t = 0;
      if (t > 255) t = 255;
      r    = $urandom_range(0, 15);
      mode = $urandom_range(0, 9);
      if (mode == 0) issue(s, s, r, 1'b1, -1);
      else if (mode == 1) issue(s, t, r, 1'b0, -1);
      else if (mode == 2) issue(s, t, r, 1'b1, $urandom_range(0, 6));
      else issue(s, t, r, 1'b1, -1);
    end

    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
